// File: rtl/img_stream_pkg.sv
// rtl/img_stream_pkg.sv - shared state encodings and padded-geometry helpers for image stream blocks
package img_stream_pkg;

    localparam int PIX_W     = 16;
    localparam int PAYLOAD_W = PIX_W + 2;

    typedef enum logic [1:0] {
        ST_BORDER_ROW = 2'd0,
        ST_LEFT_PIX   = 2'd1,
        ST_DATA       = 2'd2,
        ST_RIGHT_PIX  = 2'd3
    } state_t;

    // Index of the last pixel/row of a padded dimension (interior size + 1).
    function automatic logic [15:0] pad_last(input int res);
        return 16'(res + 1);
    endfunction

endpackage

// File: rtl/axis_img_border_strip_if.sv
// rtl/axis_img_border_strip_if.sv - pixel stream bundle with master/slave views
interface axis_img_border_strip_if;

    logic [15:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        tuser;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );

endinterface

// File: rtl/axis_pix_out_reg.sv
// rtl/axis_pix_out_reg.sv - one-deep output register holding {tuser, tlast, tdata}
module axis_pix_out_reg
    import img_stream_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_data,
    input  logic                 out_ready
);

    assign in_ready = ~out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_img_border_strip.sv
// rtl/axis_img_border_strip.sv - strips the one-pixel border ring from a padded frame
// Optional tuser row resync enabled by defining BORDER_STRIP_RESYNC_EN.
module axis_img_border_strip
    import img_stream_pkg::*;
#(
    parameter int          IMG_RES_X     = 336,
    parameter int          IMG_RES_Y     = 256,
    parameter logic [15:0] DATA_PIX_MASK = 16'h0000
)
(
    input  logic                    axis_aclk,
    input  logic                    axis_areset,
    axis_img_border_strip_if.slave  s_axis,
    axis_img_border_strip_if.master m_axis,
    output logic                    frame_done,
    output logic                    row_err
);

    localparam logic [15:0] X_END  = 16'(IMG_RES_X);
    localparam logic [15:0] X_LAST = pad_last(IMG_RES_X);
    localparam logic [15:0] Y_LAST = pad_last(IMG_RES_Y);

    state_t         state;
    logic [15:0]    x_cnt;
    logic [15:0]    y_cnt;
    logic [15:0]    y_inc;
    state_t         row_next;
    logic           accept;
    logic           at_x_last;
    logic           row_end;
    logic           tuser_err;
    logic           fwd;
    logic           reg_ready;
    logic           out_valid;
    logic [PAYLOAD_W-1:0] fwd_data;
    logic [PAYLOAD_W-1:0] out_data;
    logic           unused_ok;

    assign at_x_last = (x_cnt == X_LAST);

`ifdef BORDER_STRIP_RESYNC_EN
    assign row_end   = at_x_last | s_axis.tuser;
    assign tuser_err = s_axis.tuser ^ at_x_last;
    assign unused_ok = s_axis.tlast;
`else
    assign row_end   = at_x_last;
    assign tuser_err = 1'b0;
    assign unused_ok = s_axis.tlast ^ s_axis.tuser;
`endif

    assign s_axis.tready = reg_ready & ~axis_areset;
    assign accept        = s_axis.tvalid & s_axis.tready;

    // A row cut short by resync drops the terminating beat, so no tlast for that row.
    assign fwd      = accept & (state == ST_DATA) & ~row_end;
    assign fwd_data = {(y_cnt == 16'd1) && (x_cnt == 16'd1),
                       (x_cnt == X_END),
                       s_axis.tdata & ~DATA_PIX_MASK};

    assign y_inc    = y_cnt + 16'd1;
    assign row_next = (y_inc == Y_LAST) ? ST_BORDER_ROW : ST_LEFT_PIX;

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            state      <= ST_BORDER_ROW;
            x_cnt      <= '0;
            y_cnt      <= '0;
            frame_done <= 1'b0;
            row_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            row_err    <= accept & tuser_err;
            if (accept) begin
                case (state)
                    ST_BORDER_ROW: begin
                        if (row_end) begin
                            x_cnt <= '0;
                            if (y_cnt == 16'd0) begin
                                y_cnt <= 16'd1;
                                state <= ST_LEFT_PIX;
                            end else if (y_cnt == Y_LAST) begin
                                frame_done <= 1'b1;
                                y_cnt      <= '0;
                            end
                        end else begin
                            x_cnt <= x_cnt + 16'd1;
                        end
                    end
                    ST_LEFT_PIX, ST_DATA: begin
                        if (row_end) begin
                            x_cnt <= '0;
                            y_cnt <= y_inc;
                            state <= row_next;
                        end else begin
                            x_cnt <= x_cnt + 16'd1;
                            if (state == ST_LEFT_PIX)
                                state <= ST_DATA;
                            else if (x_cnt == X_END)
                                state <= ST_RIGHT_PIX;
                        end
                    end
                    default: begin
                        x_cnt <= '0;
                        y_cnt <= y_inc;
                        state <= row_next;
                    end
                endcase
            end
        end
    end

    axis_pix_out_reg u_out_reg (
        .clk       (axis_aclk),
        .rst       (axis_areset),
        .in_valid  (fwd),
        .in_data   (fwd_data),
        .in_ready  (reg_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (m_axis.tready)
    );

    assign m_axis.tvalid = out_valid;
    assign m_axis.tdata  = out_data[PIX_W-1:0];
    assign m_axis.tlast  = out_data[PIX_W];
    assign m_axis.tuser  = out_data[PIX_W+1];

endmodule

// File: tb/tb_axis_img_border_strip.sv
// tb/tb_axis_img_border_strip.sv - self-checking bench for axis_img_border_strip
module tb_axis_img_border_strip;

    localparam int          RX   = 4;
    localparam int          RY   = 3;
    localparam int          PW   = RX + 2;
    localparam int          PH   = RY + 2;
    localparam logic [15:0] MASK = 16'h8000;

    typedef struct {
        string name;
        int    pattern;   // 0 ramp, 1 all ones, 2 random
        int    nframes;
        int    rmode;     // 1 always ready, 2 toggle, 3 random
        bit    gaps;
        int    exp_beats;
        int    exp_done;
    } scen_t;

    typedef struct {
        logic [15:0] d;
        logic        l;
        logic        u;
    } vec_t;

    logic axis_aclk = 1'b0;
    logic axis_areset = 1'b1;
    logic frame_done;
    logic row_err;

    axis_img_border_strip_if s_if ();
    axis_img_border_strip_if m_if ();

    axis_img_border_strip #(
        .IMG_RES_X     (RX),
        .IMG_RES_Y     (RY),
        .DATA_PIX_MASK (MASK)
    ) dut (
        .axis_aclk   (axis_aclk),
        .axis_areset (axis_areset),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .frame_done  (frame_done),
        .row_err     (row_err)
    );

    always #5 axis_aclk = ~axis_aclk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          ready_mode = 0;
    int          acc_cycles = 0;
    logic [17:0] cap_q[$];
    logic [17:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge axis_aclk) begin
        if (!axis_areset) begin
            if (m_if.tvalid && m_if.tready)
                cap_q.push_back({m_if.tuser, m_if.tlast, m_if.tdata});
            if (frame_done)
                done_cnt++;
        end
    end

    initial begin
        forever begin
            @(posedge axis_aclk);
            #1;
            case (ready_mode)
                1: m_if.tready = 1'b1;
                2: m_if.tready = ~m_if.tready;
                3: m_if.tready = 1'($urandom_range(0, 1));
                default: ;
            endcase
        end
    end

    task automatic drive_beat(input logic [15:0] d, input logic u, input bit gaps);
        logic acc;
        acc = 1'b0;
        if (gaps && $urandom_range(0, 2) == 0) begin
            s_if.tvalid = 1'b0;
            repeat ($urandom_range(1, 3)) begin
                @(posedge axis_aclk);
                #1;
            end
        end
        s_if.tdata  = d;
        s_if.tuser  = u;
        s_if.tvalid = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            @(negedge axis_aclk);
            acc = s_if.tready;
            @(posedge axis_aclk);
            #1;
            acc_cycles++;
            if (acc) break;
        end
        if (!acc) check("accept_timeout", 32'(acc), 32'd1);
        s_if.tvalid = 1'b0;
    endtask

    // Reference: the interior of every padded frame, row-major, with framing flags from position.
    task automatic run_scenario(input scen_t sc);
        logic [15:0] p;
        cap_q.delete();
        exp_q.delete();
        done_cnt   = 0;
        acc_cycles = 0;
        ready_mode = sc.rmode;
        for (int f = 0; f < sc.nframes; f++) begin
            for (int r = 0; r < PH; r++) begin
                for (int c = 0; c < PW; c++) begin
                    case (sc.pattern)
                        0:       p = 16'(r * PW + c);
                        1:       p = 16'hFFFF;
                        default: p = 16'($urandom);
                    endcase
                    if (r >= 1 && r <= RY && c >= 1 && c <= RX)
                        exp_q.push_back({(r == 1 && c == 1), (c == RX), p & ~MASK});
                    drive_beat(p, (c == PW - 1), sc.gaps);
                end
            end
        end
        if (!sc.gaps && sc.rmode == 1)
            check({sc.name, "_throughput_cycles"}, 32'(acc_cycles), 32'(sc.nframes * PW * PH));
        ready_mode = 1;
        for (int t = 0; t < 200; t++) begin
            if (cap_q.size() >= exp_q.size()) break;
            @(posedge axis_aclk);
            #1;
        end
        repeat (4) begin
            @(posedge axis_aclk);
            #1;
        end
        check({sc.name, "_beat_count_model"}, 32'(cap_q.size()), 32'(exp_q.size()));
        check({sc.name, "_beat_count_table"}, 32'(cap_q.size()), 32'(sc.exp_beats));
        check({sc.name, "_frame_done"}, 32'(done_cnt), 32'(sc.exp_done));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < cap_q.size())
                check($sformatf("%s_beat%0d", sc.name, i), 32'(cap_q[i]), 32'(exp_q[i]));
        end
    endtask

    scen_t scen[6];
    vec_t  ramp_tab[12];
    scen_t clean;

    initial begin
        scen[0] = '{"ramp",        0, 1, 1, 1'b0, 12, 1};
        scen[1] = '{"ones_masked", 1, 1, 1, 1'b0, 12, 1};
        scen[2] = '{"ramp_toggle", 0, 1, 2, 1'b1, 12, 1};
        scen[3] = '{"rand_rand",   2, 1, 3, 1'b1, 12, 1};
        scen[4] = '{"ramp_b2b",    0, 2, 1, 1'b0, 24, 2};
        scen[5] = '{"rand_b2b",    2, 2, 2, 1'b1, 24, 2};
        clean   = '{"post_reset",  0, 1, 1, 1'b0, 12, 1};
        ramp_tab[0]  = '{16'd7,  1'b0, 1'b1};
        ramp_tab[1]  = '{16'd8,  1'b0, 1'b0};
        ramp_tab[2]  = '{16'd9,  1'b0, 1'b0};
        ramp_tab[3]  = '{16'd10, 1'b1, 1'b0};
        ramp_tab[4]  = '{16'd13, 1'b0, 1'b0};
        ramp_tab[5]  = '{16'd14, 1'b0, 1'b0};
        ramp_tab[6]  = '{16'd15, 1'b0, 1'b0};
        ramp_tab[7]  = '{16'd16, 1'b1, 1'b0};
        ramp_tab[8]  = '{16'd19, 1'b0, 1'b0};
        ramp_tab[9]  = '{16'd20, 1'b0, 1'b0};
        ramp_tab[10] = '{16'd21, 1'b0, 1'b0};
        ramp_tab[11] = '{16'd22, 1'b1, 1'b0};

        s_if.tdata  = '0;
        s_if.tvalid = 1'b0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;

        repeat (3) @(posedge axis_aclk);
        #1;
        check("reset_s_tready", 32'(s_if.tready), 32'd0);
        check("reset_m_tvalid", 32'(m_if.tvalid), 32'd0);
        axis_areset = 1'b0;
        #1;
        check("post_reset_s_tready", 32'(s_if.tready), 32'd1);
        check("post_reset_frame_done", 32'(frame_done), 32'd0);
        check("post_reset_row_err", 32'(row_err), 32'd0);

        for (int k = 0; k < 6; k++) begin
            run_scenario(scen[k]);
            if (k == 0) begin
                for (int i = 0; i < 12; i++) begin
                    if (i < cap_q.size())
                        check($sformatf("ramp_table%0d", i), 32'(cap_q[i]),
                              32'({ramp_tab[i].u, ramp_tab[i].l, ramp_tab[i].d}));
                end
            end
            check({scen[k].name, "_row_err"}, 32'(row_err), 32'd0);
        end

        // Mid-frame reset with an output beat still pending.
        cap_q.delete();
        ready_mode = 1;
        for (int i = 0; i < 16; i++)
            drive_beat(16'(i), ((i % PW) == PW - 1), 1'b0);
        ready_mode  = 0;
        m_if.tready = 1'b0;
        @(posedge axis_aclk);
        #1;
        check("pending_valid_before_reset", 32'(m_if.tvalid), 32'd1);
        check("pending_data_before_reset", 32'(m_if.tdata), 32'd15);
        axis_areset = 1'b1;
        cap_q.delete();
        @(posedge axis_aclk);
        #1;
        check("midreset_m_tvalid", 32'(m_if.tvalid), 32'd0);
        check("midreset_s_tready", 32'(s_if.tready), 32'd0);
        axis_areset = 1'b0;
        run_scenario(clean);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
